stack_seq_ctrl: RTL

// - Parametrised multi-cycle stack sequencer for CALL, RET, RETI and hardware interrupt entry.
// - Sits beside the decode-stage control FSM; asserts busy to stall fetch/decode while it runs.
// - Serialises the PC (and flags, for interrupts) into WORD_W-wide stack pushes and reassembles pops.
// - Supersedes the fixed two-word PC push/pop states with width-generic counters, a pending-interrupt latch and a variable-latency pop handshake.

---
 rtl/stack_seq_pkg.sv | 31 +++
 rtl/pc_word_serdes.sv | 45 ++++
 rtl/stack_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types and parameter checks for the stack sequencer.
package stack_seq_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CALL = 2'd1,
    OP_RET  = 2'd2,
    OP_RETI = 2'd3
  } seq_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH_PC,
    ST_PUSH_FLAGS,
    ST_POP_FLAGS,
    ST_POP_PC
  } seq_state_t;

  function automatic bit widths_ok(
    input int pc_w,
    input int word_w,
    input int flag_w,
    input int drain
  );
    return (word_w > 0) && (pc_w >= word_w) &&
           (pc_w % word_w == 0) && (flag_w <= word_w) &&
           (drain >= 1);
  endfunction

endpackage

// File: rtl/pc_word_serdes.sv
// Word-wise PC serialiser (MS word first) and
// deserialiser (LS word first) sharing one index counter.
module pc_word_serdes #(
  parameter int PC_W   = 32,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [PC_W-1:0]   i_load_val,
  input  logic              i_step,
  input  logic              i_deser,
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_done
);

  localparam int NWORDS = PC_W / WORD_W;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [PC_W-1:0] r_reg;
  logic [IW-1:0]   r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_reg <= i_load_val;
      r_idx <= '0;
    end else if (i_step) begin
      if (i_deser)
        r_reg[int'(r_idx)*WORD_W +: WORD_W] <= i_word;
      else
        r_reg <= r_reg << WORD_W;
      r_idx <= o_done ? '0 : r_idx + IW'(1);
    end
  end

  assign o_word = r_reg[PC_W-1 -: WORD_W];
  assign o_pc   = r_reg;
  assign o_done = (r_idx == IW'(NWORDS - 1));

endmodule

// File: rtl/stack_seq_ctrl.sv
// Multi-cycle CALL/RET/RETI/interrupt stack sequencer
// that stalls decode while it pushes or pops the PC.
module stack_seq_ctrl
  import stack_seq_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter int              WORD_W       = 16,
  parameter int              FLAG_W       = 4,
  parameter int              DRAIN_CYCLES = 4,
  parameter logic [PC_W-1:0] INT_VECTOR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic              op_valid,
  input  logic [1:0]        op_kind,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [WORD_W-1:0] pop_data,
  input  logic              pop_data_valid,
  output logic              busy,
  output logic              clear_instruction,
  output logic              push_valid,
  output logic [WORD_W-1:0] push_data,
  output logic              pop_valid,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_value,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_load_value,
  output logic              int_ack
);

  if (!widths_ok(PC_W, WORD_W, FLAG_W, DRAIN_CYCLES)) begin : g_bad
    $error("stack_seq_ctrl: illegal width parameters");
  end

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  seq_state_t        r_state;
  seq_op_t           w_op;
  logic [DW-1:0]     r_drain;
  logic              r_int_pending;
  logic              r_pop_out;
  logic              r_is_int;
  logic [FLAG_W-1:0] r_flags_cap;
  logic              r_push_valid;
  logic              r_push_flags;
  logic              r_pop_valid;
  logic              r_pc_load;
  logic              r_pc_vec;
  logic              r_flags_load;
  logic [FLAG_W-1:0] r_flags_val;
  logic              r_int_ack;
  logic              r_clear;

  logic              w_int;
  logic              w_pop_arrive;
  logic              w_ser_load;
  logic              w_ser_step;
  logic              w_ser_deser;
  logic              w_ser_done;
  logic [WORD_W-1:0] w_ser_word;
  logic [PC_W-1:0]   w_ser_pc;

  assign w_op         = seq_op_t'(op_kind);
  assign w_int        = r_int_pending | int_req;
  assign w_pop_arrive = r_pop_out & pop_data_valid;

  always_comb begin
    w_ser_load  = 1'b0;
    w_ser_step  = 1'b0;
    w_ser_deser = 1'b0;
    unique case (r_state)
      ST_IDLE:    w_ser_load = w_int | op_valid;
      ST_PUSH_PC: w_ser_step = 1'b1;
      ST_POP_PC: begin
        w_ser_step  = w_pop_arrive;
        w_ser_deser = 1'b1;
      end
      default: ;
    endcase
  end

  pc_word_serdes #(
    .PC_W   (PC_W),
    .WORD_W (WORD_W)
  ) u_serdes (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ser_load),
    .i_load_val (pc_in),
    .i_step     (w_ser_step),
    .i_deser    (w_ser_deser),
    .i_word     (pop_data),
    .o_word     (w_ser_word),
    .o_pc       (w_ser_pc),
    .o_done     (w_ser_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_drain       <= '0;
      r_int_pending <= 1'b0;
      r_pop_out     <= 1'b0;
      r_is_int      <= 1'b0;
      r_flags_cap   <= '0;
      r_push_valid  <= 1'b0;
      r_push_flags  <= 1'b0;
      r_pop_valid   <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_vec      <= 1'b0;
      r_flags_load  <= 1'b0;
      r_flags_val   <= '0;
      r_int_ack     <= 1'b0;
      r_clear       <= 1'b0;
    end else begin
      r_push_valid <= 1'b0;
      r_push_flags <= 1'b0;
      r_pop_valid  <= 1'b0;
      r_pc_load    <= 1'b0;
      r_pc_vec     <= 1'b0;
      r_flags_load <= 1'b0;
      r_flags_val  <= '0;
      r_int_ack    <= 1'b0;
      r_clear      <= 1'b0;

      // The acknowledge cycle retires the request
      if (r_int_ack)
        r_int_pending <= 1'b0;
      else if (int_req)
        r_int_pending <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (w_int) begin
            r_state     <= ST_DRAIN;
            r_flags_cap <= flags_in;
            r_is_int    <= 1'b1;
            r_clear     <= 1'b1;
            r_drain     <= DW'(DRAIN_CYCLES - 1);
          end else if (op_valid) begin
            unique case (w_op)
              OP_CALL: begin
                r_state      <= ST_PUSH_PC;
                r_is_int     <= 1'b0;
                r_push_valid <= 1'b1;
              end
              OP_RET: begin
                r_state     <= ST_POP_PC;
                r_pop_valid <= 1'b1;
                r_pop_out   <= 1'b1;
              end
              OP_RETI: begin
                r_state     <= ST_POP_FLAGS;
                r_pop_valid <= 1'b1;
                r_pop_out   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state      <= ST_PUSH_PC;
            r_push_valid <= 1'b1;
          end else begin
            r_drain <= r_drain - DW'(1);
            r_clear <= 1'b1;
          end
        end
        ST_PUSH_PC: begin
          if (!w_ser_done) begin
            r_push_valid <= 1'b1;
          end else if (r_is_int) begin
            r_state      <= ST_PUSH_FLAGS;
            r_push_valid <= 1'b1;
            r_push_flags <= 1'b1;
            r_pc_load    <= 1'b1;
            r_pc_vec     <= 1'b1;
            r_int_ack    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PUSH_FLAGS: r_state <= ST_IDLE;
        ST_POP_FLAGS: begin
          if (w_pop_arrive) begin
            r_state      <= ST_POP_PC;
            r_flags_load <= 1'b1;
            r_flags_val  <= pop_data[FLAG_W-1:0];
            r_pop_valid  <= 1'b1;
          end
        end
        ST_POP_PC: begin
          if (r_pc_load) begin
            r_state <= ST_IDLE;
          end else if (w_pop_arrive) begin
            if (w_ser_done) begin
              r_pop_out <= 1'b0;
              r_pc_load <= 1'b1;
            end else begin
              r_pop_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy              = (r_state != ST_IDLE);
  assign clear_instruction = r_clear;
  assign push_valid        = r_push_valid;
  assign push_data         = !r_push_valid ? '0 :
                             r_push_flags  ? WORD_W'(r_flags_cap) :
                                             w_ser_word;
  assign pop_valid         = r_pop_valid;
  assign pc_load           = r_pc_load;
  assign pc_load_value     = !r_pc_load ? '0 :
                             r_pc_vec   ? INT_VECTOR : w_ser_pc;
  assign flags_load        = r_flags_load;
  assign flags_load_value  = r_flags_val;
  assign int_ack           = r_int_ack;

endmodule
